// File: rtl/axil_cmd_master_if.sv
// AXI-Lite 32-bit channel bundle between a register-space initiator and the slave fabric.
interface axil_cmd_master_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one valid/ready register command in,
// one response word out, with an optional abort timer per transaction.
module axil_cmd_master #(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [2:0] AXI_PROT       = 3'b000
) (
   input  logic        axilClk,
   input  logic        axilRst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   output logic        busy,
   axil_cmd_master_if.master axil
);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;

   typedef struct packed {
      state_t      state;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        awvalid;
      logic        wvalid;
      logic        bready;
      logic        arvalid;
      logic        rready;
      logic        rsp_valid;
      logic [31:0] rsp_rdata;
      logic [1:0]  rsp_resp;
      logic        rsp_timeout;
      logic [15:0] cnt;
   } regs_t;

   localparam logic [31:0] TMO = TIMEOUT_CYCLES;

   regs_t       r_q, r_n;
   logic [15:0] cnt_inc;
   logic        tmo_hit, abort, aw_done, w_done;

   always_ff @(posedge axilClk) begin
      if (axilRst) r_q <= '0;
      else         r_q <= r_n;
   end

   always_comb begin
      r_n     = r_q;
      abort   = 1'b0;
      aw_done = 1'b0;
      w_done  = 1'b0;
      // Saturating count; a limit above 16 bits can never be reached.
      cnt_inc = (&r_q.cnt) ? r_q.cnt : r_q.cnt + 16'd1;
      tmo_hit = (TMO != 32'd0) && ({16'd0, cnt_inc} >= TMO);

      case (r_q.state)
         IDLE: begin
            if (cmd_valid) begin
               r_n.addr  = cmd_addr;
               r_n.wdata = cmd_wdata;
               r_n.wstrb = cmd_wstrb;
               r_n.cnt   = '0;
               if (cmd_write) begin
                  r_n.awvalid = 1'b1;
                  r_n.wvalid  = 1'b1;
                  r_n.state   = WR_AW_W;
               end else begin
                  r_n.arvalid = 1'b1;
                  r_n.state   = RD_AR;
               end
            end
         end
         WR_AW_W: begin
            r_n.cnt = cnt_inc;
            // A channel whose valid is already low has completed its handshake.
            aw_done = !r_q.awvalid || axil.awready;
            w_done  = !r_q.wvalid  || axil.wready;
            if (axil.awready) r_n.awvalid = 1'b0;
            if (axil.wready)  r_n.wvalid  = 1'b0;
            if (aw_done && w_done) begin
               r_n.bready = 1'b1;
               r_n.state  = WR_B;
            end else begin
               abort = tmo_hit;
            end
         end
         WR_B: begin
            r_n.cnt = cnt_inc;
            if (axil.bvalid && r_q.bready) begin
               r_n.rsp_resp  = axil.bresp;
               r_n.rsp_rdata = '0;
               r_n.bready    = 1'b0;
               r_n.rsp_valid = 1'b1;
               r_n.state     = DONE;
            end else begin
               abort = tmo_hit;
            end
         end
         RD_AR: begin
            r_n.cnt = cnt_inc;
            if (axil.arready) begin
               r_n.arvalid = 1'b0;
               r_n.rready  = 1'b1;
               r_n.state   = RD_R;
            end else begin
               abort = tmo_hit;
            end
         end
         RD_R: begin
            r_n.cnt = cnt_inc;
            if (axil.rvalid && r_q.rready) begin
               r_n.rsp_rdata = axil.rdata;
               r_n.rsp_resp  = axil.rresp;
               r_n.rready    = 1'b0;
               r_n.rsp_valid = 1'b1;
               r_n.state     = DONE;
            end else begin
               abort = tmo_hit;
            end
         end
         DONE: begin
            if (r_q.rsp_valid && rsp_ready) begin
               r_n.rsp_valid   = 1'b0;
               r_n.rsp_timeout = 1'b0;
               r_n.state       = IDLE;
            end
         end
         default: r_n.state = IDLE;
      endcase

      if (abort) begin
         r_n.awvalid     = 1'b0;
         r_n.wvalid      = 1'b0;
         r_n.bready      = 1'b0;
         r_n.arvalid     = 1'b0;
         r_n.rready      = 1'b0;
         r_n.rsp_resp    = 2'b10;
         r_n.rsp_timeout = 1'b1;
         r_n.rsp_rdata   = '0;
         r_n.rsp_valid   = 1'b1;
         r_n.state       = DONE;
      end
   end

   assign cmd_ready    = (r_q.state == IDLE);
   assign busy         = (r_q.state != IDLE);
   assign rsp_valid    = r_q.rsp_valid;
   assign rsp_rdata    = r_q.rsp_rdata;
   assign rsp_resp     = r_q.rsp_resp;
   assign rsp_timeout  = r_q.rsp_timeout;

   assign axil.awaddr  = r_q.addr;
   assign axil.awprot  = AXI_PROT;
   assign axil.awvalid = r_q.awvalid;
   assign axil.wdata   = r_q.wdata;
   assign axil.wstrb   = r_q.wstrb;
   assign axil.wvalid  = r_q.wvalid;
   assign axil.bready  = r_q.bready;
   assign axil.araddr  = r_q.addr;
   assign axil.arprot  = AXI_PROT;
   assign axil.arvalid = r_q.arvalid;
   assign axil.rready  = r_q.rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed cycle-by-cycle bench for axil_cmd_master; inputs driven and outputs sampled on the falling edge.
module tb_axil_cmd_master;
   logic        axilClk, axilRst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   int          checks = 0;
   int          failures = 0;

   axil_cmd_master_if axil();

   axil_cmd_master #(.TIMEOUT_CYCLES(16), .AXI_PROT(3'b000)) dut (
      .axilClk(axilClk), .axilRst(axilRst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .axil(axil)
   );

   initial axilClk = 1'b0;
   always #5 axilClk = ~axilClk;

   task automatic tick();
      @(negedge axilClk);
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
   endtask

   task automatic slave_idle();
      axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = 0;
      axil.arready = 0; axil.rvalid = 0; axil.rdata = 0; axil.rresp = 0;
   endtask

   task automatic test_reset();
      logic [127:0] outs;
      axilRst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; slave_idle();
      repeat (3) tick();
      outs = {axil.awaddr, axil.wdata, axil.wstrb, axil.awvalid, axil.wvalid, axil.bready,
              axil.arvalid, axil.rready, axil.awprot, axil.arprot, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy};
      checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      axilRst = 1'b0;
      tick();
   endtask

   task automatic test_write_zero_wait();
      axil.awready = 1; axil.wready = 1; axil.bvalid = 1; axil.bresp = 2'b00;
      send_cmd(1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr0_cmd_ready got=%b exp=1", cmd_ready); end
      tick(); cmd_valid = 0;
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b110) begin failures++; $display("FAIL wr0_c1_valids got=%b exp=110", {axil.awvalid, axil.wvalid, axil.bready}); end
      checks++; if (axil.awaddr !== 32'h104) begin failures++; $display("FAIL wr0_awaddr got=%h exp=00000104", axil.awaddr); end
      checks++; if (axil.wdata !== 32'hDEADBEEF || axil.wstrb !== 4'hF) begin failures++; $display("FAIL wr0_wdata got=%h/%h exp=deadbeef/f", axil.wdata, axil.wstrb); end
      checks++; if ({cmd_ready, busy} !== 2'b01) begin failures++; $display("FAIL wr0_busy got=%b exp=01", {cmd_ready, busy}); end
      tick();
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready, rsp_valid} !== 4'b0010) begin failures++; $display("FAIL wr0_c2 got=%b exp=0010", {axil.awvalid, axil.wvalid, axil.bready, rsp_valid}); end
      tick();
      checks++; if ({rsp_valid, axil.bready, rsp_resp, rsp_timeout} !== 5'b10000 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr0_c3_rsp got=%b rdata=%h exp=10000 rdata=0", {rsp_valid, axil.bready, rsp_resp, rsp_timeout}, rsp_rdata); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin failures++; $display("FAIL wr0_c4_idle got=%b exp=010", {rsp_valid, cmd_ready, busy}); end
      slave_idle();
   endtask

   task automatic test_read_wait();
      int bad = 0;
      send_cmd(0, 32'h0000_0200, 32'h0, 4'h0);
      tick(); cmd_valid = 0;
      checks++; if ({axil.arvalid, axil.rready} !== 2'b10 || axil.araddr !== 32'h200) begin failures++; $display("FAIL rd_c1 got=%b araddr=%h exp=10 araddr=00000200", {axil.arvalid, axil.rready}, axil.araddr); end
      tick();
      checks++; if (axil.arvalid !== 1'b1) begin failures++; $display("FAIL rd_arvalid_hold got=%b exp=1", axil.arvalid); end
      axil.arready = 1;
      tick(); axil.arready = 0;
      checks++; if ({axil.arvalid, axil.rready} !== 2'b01) begin failures++; $display("FAIL rd_after_ar got=%b exp=01", {axil.arvalid, axil.rready}); end
      for (int i = 0; i < 5; i++) begin
         if (axil.rready !== 1'b1 || rsp_valid !== 1'b0 || axil.arvalid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rd_wait_cycles got=%0d bad exp=0", bad); end
      axil.rvalid = 1; axil.rdata = 32'h1234_5678; axil.rresp = 2'b00;
      tick(); axil.rvalid = 0; axil.rdata = 0;
      checks++; if ({rsp_valid, axil.rready, rsp_resp, rsp_timeout} !== 5'b10000) begin failures++; $display("FAIL rd_rsp_flags got=%b exp=10000", {rsp_valid, axil.rready, rsp_resp, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_rdata got=%h exp=12345678", rsp_rdata); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL rd_release got=%b exp=01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_write_split();
      send_cmd(1, 32'h0000_0300, 32'hA5A5_0001, 4'h3);
      tick(); cmd_valid = 0;
      axil.wready = 1;
      tick(); axil.wready = 0;
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b100) begin failures++; $display("FAIL ws_w_first got=%b exp=100", {axil.awvalid, axil.wvalid, axil.bready}); end
      tick();
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b100) begin failures++; $display("FAIL ws_c3 got=%b exp=100", {axil.awvalid, axil.wvalid, axil.bready}); end
      tick();
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b100) begin failures++; $display("FAIL ws_c4 got=%b exp=100", {axil.awvalid, axil.wvalid, axil.bready}); end
      axil.awready = 1;
      tick(); axil.awready = 0;
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b001) begin failures++; $display("FAIL ws_aw_done got=%b exp=001", {axil.awvalid, axil.wvalid, axil.bready}); end
      axil.bvalid = 1; axil.bresp = 2'b01;
      tick(); axil.bvalid = 0; axil.bresp = 0;
      checks++; if ({rsp_valid, axil.bready, rsp_resp} !== 4'b1001) begin failures++; $display("FAIL ws_rsp got=%b exp=1001", {rsp_valid, axil.bready, rsp_resp}); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL ws_release got=%b exp=01", {rsp_valid, cmd_ready}); end
      // both handshakes in the same cycle
      send_cmd(1, 32'h0000_0304, 32'h0000_BEEF, 4'hC);
      tick(); cmd_valid = 0;
      tick();
      checks++; if ({axil.awvalid, axil.wvalid} !== 2'b11) begin failures++; $display("FAIL ws2_hold got=%b exp=11", {axil.awvalid, axil.wvalid}); end
      axil.awready = 1; axil.wready = 1;
      tick(); axil.awready = 0; axil.wready = 0;
      checks++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b001) begin failures++; $display("FAIL ws2_both got=%b exp=001", {axil.awvalid, axil.wvalid, axil.bready}); end
      axil.bvalid = 1;
      tick(); axil.bvalid = 0;
      checks++; if ({rsp_valid, rsp_resp} !== 3'b100) begin failures++; $display("FAIL ws2_rsp got=%b exp=100", {rsp_valid, rsp_resp}); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL ws2_release got=%b exp=01", {rsp_valid, cmd_ready}); end
   endtask

   task automatic test_timeout();
      int hi = 0;
      send_cmd(0, 32'h0000_0600, 32'h0, 4'h0);
      tick(); cmd_valid = 0;
      for (int i = 1; i <= 16; i++) begin
         if (axil.arvalid === 1'b1 && rsp_valid === 1'b0) hi++;
         tick();
      end
      checks++; if (hi != 16) begin failures++; $display("FAIL to_arvalid_cycles got=%0d exp=16", hi); end
      checks++; if ({axil.arvalid, axil.rready, rsp_valid, rsp_resp, rsp_timeout} !== 6'b001101) begin failures++; $display("FAIL to_abort got=%b exp=001101", {axil.arvalid, axil.rready, rsp_valid, rsp_resp, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", rsp_rdata); end
      tick();
      checks++; if ({rsp_valid, rsp_timeout, cmd_ready} !== 3'b110) begin failures++; $display("FAIL to_hold got=%b exp=110", {rsp_valid, rsp_timeout, cmd_ready}); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, rsp_timeout, cmd_ready} !== 3'b001) begin failures++; $display("FAIL to_release got=%b exp=001", {rsp_valid, rsp_timeout, cmd_ready}); end
      // next command completes normally
      axil.arready = 1; axil.rvalid = 1; axil.rdata = 32'hCAFE_0001; axil.rresp = 2'b00;
      send_cmd(0, 32'h0000_0010, 32'h0, 4'h0);
      tick(); cmd_valid = 0;
      tick(); tick();
      checks++; if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000 || rsp_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL to_next_rsp got=%b rdata=%h exp=1000 rdata=cafe0001", {rsp_valid, rsp_resp, rsp_timeout}, rsp_rdata); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      slave_idle();
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      axil.awready = 1; axil.wready = 1; axil.bvalid = 1; axil.bresp = 2'b11;
      send_cmd(1, 32'h0000_0400, 32'h0000_0055, 4'h1);
      tick(); tick(); tick();
      for (int i = 0; i < 10; i++) begin
         if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0 || axil.awvalid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_stall got=%0d bad exp=0", bad); end
      rsp_ready = 1; cmd_addr = 32'h0000_0404;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready, axil.awvalid} !== 3'b010) begin failures++; $display("FAIL b2b_release got=%b exp=010", {rsp_valid, cmd_ready, axil.awvalid}); end
      tick(); cmd_valid = 0;
      checks++; if (axil.awvalid !== 1'b1 || axil.awaddr !== 32'h404) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/00000404", axil.awvalid, axil.awaddr); end
      tick(); tick();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_rsp got=%b exp=1", rsp_valid); end
      rsp_ready = 1;
      tick(); rsp_ready = 0;
      checks++; if ({rsp_valid, cmd_ready, axil.awvalid} !== 3'b010) begin failures++; $display("FAIL b2b_single got=%b exp=010", {rsp_valid, cmd_ready, axil.awvalid}); end
      slave_idle();
   endtask

   task automatic test_reset_mid();
      logic [127:0] outs;
      axil.awready = 1; axil.wready = 1;
      send_cmd(1, 32'h0000_0500, 32'h0000_0077, 4'hF);
      tick(); cmd_valid = 0;
      tick();
      checks++; if ({axil.bready, busy} !== 2'b11) begin failures++; $display("FAIL rm_in_wr_b got=%b exp=11", {axil.bready, busy}); end
      axilRst = 1;
      tick(); axilRst = 0;
      outs = {axil.awaddr, axil.wdata, axil.wstrb, axil.awvalid, axil.wvalid, axil.bready,
              axil.arvalid, axil.rready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy};
      checks++; if (outs !== '0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rm_outputs got=%h cmd_ready=%b exp=0 cmd_ready=1", outs, cmd_ready); end
      axil.bvalid = 1; axil.bresp = 2'b10;
      tick(); tick();
      checks++; if ({rsp_valid, busy, axil.bready} !== 3'b000) begin failures++; $display("FAIL rm_stray_b got=%b exp=000", {rsp_valid, busy, axil.bready}); end
      slave_idle();
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_write_split();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
